// File: rtl/stream_merge_mux.sv
// Round-robin merge of 2**SELECT_WIDTH valid/ready streams into one registered, index-tagged stream.
// Define STREAM_MERGE_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module stream_merge_mux #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned SELECT_WIDTH = 2,
    localparam int unsigned N           = 1 << SELECT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        in_data [N],
    input  logic [N-1:0]            in_valid,
    output logic [N-1:0]            in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELECT_WIDTH-1:0] out_index,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic                    load_en;
    logic                    grant_found;
    logic [SELECT_WIDTH-1:0] grant_idx;
    logic [SELECT_WIDTH-1:0] search_base;
    logic [SELECT_WIDTH-1:0] cand;
    logic                    in_xfer;

`ifndef STREAM_MERGE_FIXED_PRIORITY_EN
    logic [SELECT_WIDTH-1:0] last_q;
`endif

    assign load_en = !out_valid || out_ready;

    always_comb begin
`ifdef STREAM_MERGE_FIXED_PRIORITY_EN
        search_base = '0;
`else
        search_base = last_q + SELECT_WIDTH'(1);
`endif
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        // Index arithmetic wraps modulo N because N is a power of two.
        for (int k = 0; k < int'(N); k++) begin
            cand = search_base + SELECT_WIDTH'(k);
            if (!grant_found && in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (!reset && load_en && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign in_xfer = |in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
        end else if (in_xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant_idx];
            out_index <= grant_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifndef STREAM_MERGE_FIXED_PRIORITY_EN
    // Reset to N-1 so the first search begins at channel 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= '1;
        end else if (in_xfer) begin
            last_q <= grant_idx;
        end
    end
`endif

    assert property (@(posedge clk) $onehot0(in_ready));

endmodule

// File: tb/tb_stream_merge_mux.sv
// Randomised and directed bench for stream_merge_mux, checked against a spec-level model.
module tb_stream_merge_mux;

    localparam int W  = 8;
    localparam int SW = 2;
    localparam int N  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data [N];
    logic [N-1:0]  in_valid;
    logic [N-1:0]  in_ready;
    logic [W-1:0]  out_data;
    logic [SW-1:0] out_index;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_known = 1'b0;
    int           m_last;
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_index;
    int           g_pend;

    logic [N-1:0] seen_ready;
    logic [N-1:0] exp_ready;

    always #5 clk = ~clk;

    stream_merge_mux #(
        .WIDTH        (W),
        .SELECT_WIDTH (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic int exp_grant();
        int c;
        if (reset || !(m_valid !== 1'b1 || out_ready)) return -1;
        for (int k = 0; k < N; k++) begin
`ifdef STREAM_MERGE_FIXED_PRIORITY_EN
            c = k;
`else
            c = (m_last + 1 + k) % N;
`endif
            if (in_valid[c]) return c;
        end
        return -1;
    endfunction

    // One clock: compare at the negedge, advance the model at the posedge.
    task automatic cycle();
        @(negedge clk);
        seen_ready = in_ready;
        if (m_known) begin
            g_pend    = exp_grant();
            exp_ready = '0;
            if (g_pend >= 0) exp_ready[g_pend] = 1'b1;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_ready, $time);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
            end
            checks++;
            if (out_data !== m_data || int'(out_index) != m_index) begin
                errors++;
                $display("FAIL out_word: got %h/%0d expected %h/%0d at %0t",
                         out_data, out_index, m_data, m_index, $time);
            end
        end else begin
            g_pend = -1;
        end
        @(posedge clk);
        if (reset) begin
            m_known = 1'b1;
            m_valid = 1'b0;
            m_data  = '0;
            m_index = 0;
            m_last  = N - 1;
        end else if (m_known) begin
            if (g_pend >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g_pend];
                m_index = g_pend;
                m_last  = g_pend;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        in_valid  = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0 || out_index !== '0 || seen_ready !== '0) begin
                errors++;
                $display("FAIL reset_idle: got v=%b idx=%0d rdy=%b expected 0/0/0000",
                         out_valid, out_index, seen_ready);
            end
        end
    endtask

    task automatic test_single_source();
        logic [W-1:0] vals [3];
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        out_ready = 1'b1;
        in_valid  = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            in_data[2] = vals[i];
            cycle();
            checks++;
            if (seen_ready !== 4'b0100 || out_valid !== 1'b1 || out_data !== vals[i] ||
                out_index !== 2'd2) begin
                errors++;
                $display("FAIL single_source: got rdy=%b %h/%0d v=%b expected 0100 %h/2 v=1",
                         seen_ready, out_data, out_index, out_valid, vals[i]);
            end
        end
        in_valid = '0;
        cycle();
    endtask

    task automatic test_round_robin();
        int exp_seq [6];
        exp_seq = '{0, 1, 2, 3, 0, 1};
        do_reset();
        for (int i = 0; i < N; i++) in_data[i] = 8'hA0 + 8'(i);
        in_valid  = '1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (int'(out_index) != exp_seq[i] || out_data !== 8'hA0 + 8'(exp_seq[i])) begin
                errors++;
                $display("FAIL round_robin[%0d]: got %h/%0d expected %h/%0d", i,
                         out_data, out_index, 8'hA0 + 8'(exp_seq[i]), exp_seq[i]);
            end
        end
        in_valid = '0;
        cycle();
    endtask

    task automatic test_backpressure();
        in_data[1] = 8'h5A;
        in_valid   = 4'b0010;
        out_ready  = 1'b0;
        cycle();
        in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i == 1) ? 4'b1111 : 4'b0000;
            cycle();
            checks++;
            if (seen_ready !== '0 || out_valid !== 1'b1 || out_data !== 8'h5A ||
                out_index !== 2'd1) begin
                errors++;
                $display("FAIL backpressure_hold: got rdy=%b %h/%0d v=%b expected 0000 5a/1 v=1",
                         seen_ready, out_data, out_index, out_valid);
            end
        end
        in_valid  = '0;
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        in_data[3] = 8'hC3;
        in_valid   = 4'b1000;
        out_ready  = 1'b0;
        cycle();
        reset    = 1'b1;
        in_valid = '1;
        cycle();
        checks++;
        if (seen_ready !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b v=%b expected 0000 v=0", seen_ready, out_valid);
        end
        out_ready = 1'b1;
        cycle();
        checks++;
        if (seen_ready !== '0) begin
            errors++;
            $display("FAIL reset_held_ready: got %b expected 0000", seen_ready);
        end
        reset = 1'b0;
        cycle();
        checks++;
        if (seen_ready !== 4'b0001 || out_index !== 2'd0) begin
            errors++;
            $display("FAIL reset_restart: got rdy=%b idx=%0d expected 0001/0",
                     seen_ready, out_index);
        end
        in_valid = '0;
        cycle();
    endtask

    task automatic test_priority();
        logic [N-1:0] want;
        do_reset();
        in_data[1] = 8'h01;
        in_data[3] = 8'h03;
        in_valid   = 4'b1010;
        out_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef STREAM_MERGE_FIXED_PRIORITY_EN
            want = 4'b0010;
`else
            want = (i % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
            cycle();
            checks++;
            if (seen_ready !== want) begin
                errors++;
                $display("FAIL priority[%0d]: got %b expected %b", i, seen_ready, want);
            end
        end
        in_valid = 4'b1000;
        cycle();
        checks++;
        if (seen_ready !== 4'b1000) begin
            errors++;
            $display("FAIL priority_drop: got %b expected 1000", seen_ready);
        end
        in_valid = '0;
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++) in_data[c] = W'($urandom);
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 99) == 0);
            cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_data[i] = '0;
        #1;
        test_reset();
        test_single_source();
        test_round_robin();
        test_backpressure();
        test_reset_midstream();
        test_priority();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
